// File: rtl/add_sub_mux8.sv
// Registered ripple ALU slice: add/subtract full-adder chain feeding an 8:1
// result mux, with the result and MSB carry captured every clock.

module add_sub #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_eff;

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    c     = '0;
    sum   = '0;
    b_eff = b ^ {WIDTH{sub}};
    c[0]  = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
    end
    cout = c[WIDTH];
  end

endmodule

module mux8_1 #(
  parameter int WIDTH = 1
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      default: y = d7;
    endcase
  end

endmodule

module add_sub_mux8 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] ri,
  output logic             cout
);

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] result;

  // The adder always sees sel[0] as its subtract control, so cout tracks the
  // adder even when the mux selects a logic op or a reserved code.
  add_sub #(.WIDTH(WIDTH)) u_add_sub (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sel[0]),
    .sum  (sum),
    .cout (carry)
  );

  // Logic ops use raw b; reserved codes 001 and 111 yield zero.
  mux8_1 #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .d0  (b),
    .d1  ('0),
    .d2  (sum),
    .d3  (sum),
    .d4  (a & b),
    .d5  (a | b),
    .d6  (a ^ b),
    .d7  ('0),
    .y   (result)
  );

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ri   <= '0;
      cout <= 1'b0;
    end else begin
      ri   <= result;
      cout <= carry;
    end
  end

endmodule

// File: tb/tb_add_sub_mux8.sv
// Self-checking bench for add_sub_mux8: directed cases, exhaustive WIDTH=1
// sweep and randomized WIDTH=4 vectors against an arithmetic reference model.

module tb_add_sub_mux8;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] a1, b1;
  logic       cin1;
  logic [2:0] sel1;
  logic [0:0] ri1;
  logic       cout1;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [2:0] sel4;
  logic [3:0] ri4;
  logic       cout4;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sub_mux8 #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .cin(cin1), .sel(sel1),
    .ri(ri1), .cout(cout1)
  );

  add_sub_mux8 #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .a(a4), .b(b4), .cin(cin4), .sel(sel4),
    .ri(ri4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result in bits [w-1:0], carry out in bit 4.
  function automatic int model(input int w, input int av, input int bv,
                               input int ci, input logic [2:0] s);
    int mask, beff, total, r;
    mask  = (1 << w) - 1;
    beff  = s[0] ? (~bv & mask) : bv;
    total = av + beff + ci;
    case (s)
      3'd0:       r = bv;
      3'd2, 3'd3: r = total & mask;
      3'd4:       r = av & bv;
      3'd5:       r = av | bv;
      3'd6:       r = av ^ bv;
      default:    r = 0;
    endcase
    return (((total >> w) & 1) << 4) | r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply1(input string tag, input int av, input int bv, input int ci,
                        input logic [2:0] s, input int exp_ri, input int exp_cout);
    a1 = av[0:0]; b1 = bv[0:0]; cin1 = ci[0]; sel1 = s;
    tick();
    check({tag, ".ri"}, 32'(ri1), 32'(exp_ri));
    check({tag, ".cout"}, 32'(cout1), 32'(exp_cout));
  endtask

  task automatic apply4(input string tag, input int av, input int bv, input int ci,
                        input logic [2:0] s, input int exp_ri, input int exp_cout);
    a4 = av[3:0]; b4 = bv[3:0]; cin4 = ci[0]; sel4 = s;
    tick();
    check({tag, ".ri"}, 32'(ri4), 32'(exp_ri));
    check({tag, ".cout"}, 32'(cout4), 32'(exp_cout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    logic [5:0] v;
    logic [2:0] s;
    int av, bv, ci;

    reset = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sel1 = 3'b010;
    a4 = 4'hf; b4 = 4'hf; cin4 = 1'b1; sel4 = 3'b010;
    tick(); tick();
    check("reset.ri1", 32'(ri1), 32'd0);
    check("reset.cout1", 32'(cout1), 32'd0);
    check("reset.ri4", 32'(ri4), 32'd0);
    check("reset.cout4", 32'(cout4), 32'd0);
    reset = 1'b0;
    apply1("release", 1, 1, 1, 3'b010, 1, 1);

    apply1("add11", 1, 1, 0, 3'b010, 0, 1);
    apply1("add10", 1, 0, 0, 3'b010, 1, 0);
    apply1("sub11", 1, 1, 1, 3'b011, 0, 1);
    apply1("sub01", 0, 1, 1, 3'b011, 1, 0);
    apply1("and",   1, 0, 0, 3'b100, 0, 0);
    apply1("or",    1, 0, 0, 3'b101, 1, 1);
    apply1("xor",   1, 0, 0, 3'b110, 1, 0);
    apply1("passb", 1, 0, 0, 3'b000, 0, 0);
    apply1("rsv001", 1, 0, 0, 3'b001, 0, 1);
    apply1("rsv111", 1, 0, 0, 3'b111, 0, 1);

    for (int i = 0; i < 64; i++) begin
      v  = i[5:0];
      av = int'(v[5]); bv = int'(v[4]); s = v[3:1]; ci = int'(v[0]);
      m  = model(1, av, bv, ci, s);
      apply1($sformatf("exh%0d", i), av, bv, ci, s, m & 1, (m >> 4) & 1);
    end

    apply4("w4sub", 4'b0101, 4'b0011, 1, 3'b011, 4'b0010, 1);
    apply4("w4add", 4'b1111, 4'b0001, 0, 3'b010, 4'b0000, 1);

    for (int i = 0; i < 300; i++) begin
      av = int'($urandom_range(15, 0));
      bv = int'($urandom_range(15, 0));
      ci = int'($urandom_range(1, 0));
      s  = 3'($urandom_range(7, 0));
      m  = model(4, av, bv, ci, s);
      apply4($sformatf("rnd%0d", i), av, bv, ci, s, m & 15, (m >> 4) & 1);
    end

    // Mid-stream reset discards the result computed on that same edge.
    reset = 1'b1;
    apply4("midrst", 4'b1111, 4'b0001, 0, 3'b010, 0, 0);
    reset = 1'b0;
    apply4("postrst", 4'b0110, 4'b0011, 0, 3'b110, 4'b0101, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
